frame_update_sequencer: RTL and testbench

Per-frame scheduler for the game-logic units (player, dragon head, dragon body, sheep). On each frame_end it issues one-cycle start pulses to the units in fixed index order, waiting for each unit's done before starting the next. Per-unit frame-rate dividers replace ad-hoc movement-delay counters. Overrun and timeout errors are reported to the top level.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/unit_rate_divider.sv | 32 +++
 rtl/frame_update_sequencer.sv | 167 ++++++++++++++++
 tb/tb_frame_update_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the frame update sequencer.
// Unit indices name the game-logic blocks in start order.
package seq_pkg;

    localparam int SEQ_RATE_W  = 4;
    localparam int SEQ_TIMEOUT = 1023;
    localparam int SEQ_TMO_W   = $clog2(SEQ_TIMEOUT + 1);

    localparam int UNIT_PLAYER      = 0;
    localparam int UNIT_DRAGON_HEAD = 1;
    localparam int UNIT_DRAGON_BODY = 2;
    localparam int UNIT_SHEEP       = 3;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/unit_rate_divider.sv
// Per-unit frame divider: due when the count is zero, then
// reloads; otherwise counts down once per accepted frame.
module unit_rate_divider
    import seq_pkg::*;
#(
    parameter int RATE_W = SEQ_RATE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [RATE_W-1:0] reload_val,
    output logic              is_due
);

    logic [RATE_W-1:0] cnt;

    // Reload on a due frame, count down on the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            if (cnt == '0) begin
                cnt <= reload_val;
            end else begin
                cnt <= cnt - RATE_W'(1);
            end
        end
    end

    assign is_due = (cnt == '0);

endmodule

// File: rtl/frame_update_sequencer.sv
// Starts each due game-logic unit in index order once per frame.
// Optional SEQ_PAUSE_EN adds pause_i to ignore frames while idle.
module frame_update_sequencer
    import seq_pkg::*;
#(
    parameter int N_UNITS        = 4,
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT,
    parameter int RATE_W         = SEQ_RATE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_end,
`ifdef SEQ_PAUSE_EN
    input  logic                      pause_i,
`endif
    input  logic [N_UNITS-1:0]        enable_mask,
    input  logic [N_UNITS*RATE_W-1:0] rate_div,
    input  logic [N_UNITS-1:0]        done_i,
    output logic [N_UNITS-1:0]        start_o,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun,
    output logic [N_UNITS-1:0]        timeout_err,
    output logic [7:0]                frame_count
);

    localparam int IW = $clog2(N_UNITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tcnt;
    logic [N_UNITS-1:0] due;
    logic [N_UNITS-1:0] unit_due;
    logic [N_UNITS-1:0] sel;
    logic              pause;
    logic              accept;
    logic              cur_due;
    logic              cur_done;
    logic              tmo_hit;
    logic              idx_last;
    logic              idx_end;

`ifdef SEQ_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif

    assign accept   = (state == IDLE) && frame_end && !pause;
    assign cur_due  = |(due & sel);
    assign cur_done = |(done_i & sel);
    assign tmo_hit  = (tcnt == TW'(TIMEOUT_CYCLES));
    assign idx_last = (idx == IW'(N_UNITS - 1));
    assign idx_end  = (idx == IW'(N_UNITS));

    for (genvar k = 0; k < N_UNITS; k++) begin : g_div
        unit_rate_divider #(
            .RATE_W(RATE_W)
        ) u_div (
            .clk       (clk),
            .rst_n     (rst_n),
            .accept    (accept),
            .reload_val(rate_div[k*RATE_W +: RATE_W]),
            .is_due    (unit_due[k])
        );
    end

    // One-hot decode of the unit currently being handled.
    always_comb begin
        sel = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (idx == IW'(k)) begin
                sel[k] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pulse outputs.
    always_comb begin
        state_nxt  = state;
        start_o    = '0;
        frame_done = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (idx_end) begin
                    state_nxt = FINISH;
                end else if (cur_due) begin
                    state_nxt = ISSUE;
                end else if (idx_last) begin
                    state_nxt = FINISH;
                end
            end
            ISSUE: begin
                start_o   = sel;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cur_done || tmo_hit) begin
                    state_nxt = SCAN;
                end
            end
            FINISH: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame snapshot, index walk, wait timer and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            tcnt        <= '0;
            due         <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
            timeout_err <= '0;
        end else begin
            if (accept) begin
                frame_count <= frame_count + 8'd1;
                due         <= enable_mask & unit_due;
                idx         <= IW'(UNIT_PLAYER);
            end
            if (frame_end && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state == SCAN && !idx_end && !cur_due && !idx_last) begin
                idx <= idx + IW'(1);
            end
            if (state == ISSUE) begin
                tcnt <= '0;
            end
            if (state == WAIT) begin
                if (cur_done || tmo_hit) begin
                    idx <= idx + IW'(1);
                    if (!cur_done) begin
                        timeout_err <= timeout_err | sel;
                    end
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Bench for frame_update_sequencer: fixed vectors, corner
// sequences and random frames against a timeline model.
module tb_frame_update_sequencer;
    import seq_pkg::*;

    localparam int N = 4;
    localparam int T = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_end = 1'b0;
    logic [3:0]  enable_mask = '0;
    logic [15:0] rate_div = '0;
    logic [3:0]  done_i = '0;
`ifdef SEQ_PAUSE_EN
    logic        pause_i = 1'b0;
`endif
    logic [3:0]  start_o;
    logic        busy;
    logic        frame_done;
    logic        overrun;
    logic [3:0]  timeout_err;
    logic [7:0]  frame_count;

    frame_update_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end  (frame_end),
`ifdef SEQ_PAUSE_EN
        .pause_i    (pause_i),
`endif
        .enable_mask(enable_mask),
        .rate_div   (rate_div),
        .done_i     (done_i),
        .start_o    (start_o),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] rd;
        logic [7:0]  s0, s1, s2, s3, fin, fc;
    } vec_t;

    vec_t tbl [8];

    int checks = 0;
    int errors = 0;

    int lat    [4];
    int st_abs [4];
    int act_st [4];
    int act_n  [4];
    int exp_st [4];
    int cnt_m  [4];
    int act_fin, exp_fin, fe_cyc, bad_oh, fc_m;
    logic [3:0] started;
    logic [3:0] toe_m;
    logic       ovr_m;
    bit         noise_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int rel(input logic [7:0] v);
        return (v == 8'hFF) ? -1 : int'(v);
    endfunction

    // Done pulses at start+lat, plus noise on bits not waited on.
    task automatic gen_done();
        logic [3:0] d;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (started[k] && lat[k] > 0 && cyc == st_abs[k] + lat[k])
                d[k] = 1'b1;
            if (noise_en && $urandom_range(0, 3) == 0) begin
                if (!(started[k] && cyc > st_abs[k] &&
                      (lat[k] == 0 || cyc <= st_abs[k] + lat[k])))
                    d[k] = 1'b1;
            end
        end
        done_i = d;
    endtask

    task automatic step(input logic fe);
        @(posedge clk);
        #1;
        frame_end = fe;
        if (noise_en && !fe) enable_mask = 4'($urandom);
        gen_done();
        @(negedge clk);
    endtask

    task automatic smp();
        if (!$onehot0(start_o)) bad_oh++;
        for (int k = 0; k < N; k++) begin
            if (start_o[k]) begin
                act_n[k]++;
                if (act_st[k] < 0) act_st[k] = cyc - fe_cyc;
                st_abs[k]  = cyc;
                started[k] = 1'b1;
            end
        end
        if (frame_done && act_fin < 0) act_fin = cyc - fe_cyc;
    endtask

    task automatic model_init();
        for (int k = 0; k < N; k++) cnt_m[k] = 0;
        fc_m  = 0;
        ovr_m = 1'b0;
        toe_m = '0;
    endtask

    // Timeline of one accepted frame from the scheduling rules.
    task automatic model_frame(input logic [3:0] en);
        logic [3:0] due;
        int p;
        for (int k = 0; k < N; k++) begin
            due[k] = en[k] && cnt_m[k] == 0;
            if (cnt_m[k] == 0) cnt_m[k] = int'(rate_div[k*4 +: 4]);
            else cnt_m[k] = cnt_m[k] - 1;
        end
        fc_m = (fc_m + 1) % 256;
        p = 1;
        exp_fin = -1;
        for (int k = 0; k < N; k++) begin
            exp_st[k] = -1;
            if (due[k]) begin
                exp_st[k] = p + 1;
                if (lat[k] > 0) begin
                    p = p + 1 + lat[k] + 1;
                end else begin
                    p = p + 1 + T + 2;
                    toe_m[k] = 1'b1;
                end
            end else if (k == N - 1) begin
                exp_fin = p + 1;
            end else begin
                p++;
            end
        end
        if (exp_fin < 0) exp_fin = p + 1;
    endtask

    task automatic do_frame(input logic [3:0] en, input int ov_off,
                            input int bound);
        for (int k = 0; k < N; k++) begin
            act_st[k] = -1;
            act_n[k]  = 0;
        end
        started = '0;
        act_fin = -1;
        bad_oh  = 0;
        enable_mask = en;
        step(1'b1);
        fe_cyc = cyc;
        smp();
        for (int i = 1; i < bound && act_fin < 0; i++) begin
            step(1'(ov_off == i));
            smp();
            if (i == 1) chk("busy_on", int'(busy), 1);
        end
        if (act_fin < 0) chk("frame_done_seen", 0, 1);
        step(1'b0);
        smp();
        chk("busy_off", int'(busy), 0);
        repeat (2) begin
            step(1'b0);
            smp();
        end
        chk("onehot", bad_oh, 0);
    endtask

    task automatic cmp_frame(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s start%0d", tag, k), act_st[k], exp_st[k]);
            chk($sformatf("%s pulses%0d", tag, k), act_n[k],
                (exp_st[k] >= 0) ? 1 : 0);
        end
        chk({tag, " frame_done"}, act_fin, exp_fin);
        chk({tag, " frame_count"}, int'(frame_count), fc_m);
        chk({tag, " overrun"}, int'(overrun), int'(ovr_m));
        chk({tag, " timeout_err"}, int'(timeout_err), int'(toe_m));
    endtask

    task automatic reset_dut();
        noise_en = 0;
        started  = '0;
        rst_n    = 1'b0;
        repeat (2) step(1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        frame_end = 1'b0;
        done_i    = '0;
        model_init();
        @(negedge clk);
    endtask

    initial begin
        int nst, ov;
        tbl[0] = '{4'hF, 16'h0020, 8'd2, 8'd7, 8'd12, 8'd17, 8'd22, 8'd1};
        tbl[1] = '{4'hF, 16'h0020, 8'd2, 8'hFF, 8'd8, 8'd13, 8'd18, 8'd2};
        tbl[2] = '{4'hF, 16'h0020, 8'd2, 8'hFF, 8'd8, 8'd13, 8'd18, 8'd3};
        tbl[3] = '{4'hF, 16'h0020, 8'd2, 8'd7, 8'd12, 8'd17, 8'd22, 8'd4};
        tbl[4] = '{4'hF, 16'h0020, 8'd2, 8'hFF, 8'd8, 8'd13, 8'd18, 8'd5};
        tbl[5] = '{4'hF, 16'h0020, 8'd2, 8'hFF, 8'd8, 8'd13, 8'd18, 8'd6};
        tbl[6] = '{4'h0, 16'h0020, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd5, 8'd7};
        tbl[7] = '{4'hA, 16'h0020, 8'hFF, 8'hFF, 8'hFF, 8'd5, 8'd10, 8'd8};

        for (int k = 0; k < N; k++) lat[k] = 3;
        reset_dut();
        chk("rst start_o", int'(start_o), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst frame_done", int'(frame_done), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst timeout_err", int'(timeout_err), 0);
        chk("rst frame_count", int'(frame_count), 0);

        for (int i = 0; i < 8; i++) begin
            rate_div  = tbl[i].rd;
            exp_st[0] = rel(tbl[i].s0);
            exp_st[1] = rel(tbl[i].s1);
            exp_st[2] = rel(tbl[i].s2);
            exp_st[3] = rel(tbl[i].s3);
            exp_fin   = rel(tbl[i].fin);
            fc_m      = int'(tbl[i].fc);
            do_frame(tbl[i].en, 0, 200);
            cmp_frame($sformatf("vec%0d", i));
        end

        // Unit that never finishes is abandoned after the timeout.
        rate_div = '0;
        reset_dut();
        lat[UNIT_DRAGON_BODY] = 0;
        model_frame(4'hF);
        do_frame(4'hF, 0, 5000);
        cmp_frame("timeout");
        chk("tmo unit3 start", act_st[UNIT_SHEEP], 12 + T + 3);
        chk("tmo err bits", int'(timeout_err), 4);
        lat[UNIT_DRAGON_BODY] = 3;

        // Frame end during the finish cycle is dropped.
        reset_dut();
        model_frame(4'hF);
        ovr_m = 1'b1;
        do_frame(4'hF, exp_fin, 200);
        cmp_frame("overrun");

        // Reset while waiting on unit 0 aborts the sequence.
        reset_dut();
        enable_mask = 4'hF;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("pre-reset start0", int'(start_o), 1);
        step(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst start_o", int'(start_o), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst frame_count", int'(frame_count), 0);
        nst = 0;
        repeat (4) begin
            step(1'b0);
            if (start_o != '0) nst++;
        end
        chk("midrst no starts", nst, 0);
        model_init();
        model_frame(4'hF);
        do_frame(4'hF, 0, 200);
        cmp_frame("after_rst");

`ifdef SEQ_PAUSE_EN
        reset_dut();
        pause_i = 1'b1;
        nst = 0;
        repeat (3) begin
            step(1'b1);
            repeat (3) begin
                step(1'b0);
                if (start_o != '0) nst++;
            end
        end
        pause_i = 1'b0;
        chk("pause starts", nst, 0);
        chk("pause frame_count", int'(frame_count), 0);
        chk("pause overrun", int'(overrun), 0);
`endif

        // Random frames with noise on idle done bits.
        reset_dut();
        for (int f = 0; f < 30; f++) begin
            logic [3:0] en;
            en       = 4'($urandom);
            rate_div = 16'($urandom) & 16'h3333;
            for (int k = 0; k < N; k++) begin
                lat[k] = ($urandom_range(0, 39) == 0) ? 0
                                                      : $urandom_range(1, 5);
            end
            model_frame(en);
            ov = 0;
            if ($urandom_range(0, 1) == 1) begin
                ov    = $urandom_range(1, exp_fin);
                ovr_m = 1'b1;
            end
            noise_en = 1;
            do_frame(en, ov, 5000);
            cmp_frame($sformatf("rnd%0d", f));
            repeat ($urandom_range(0, 2)) step(1'b0);
        end
        noise_en = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
